addsub_issue_queue: RTL and testbench
=====================================

ADDSUB_ISSUE_QUEUE -- requirements
Module: addsub_issue_queue

Interface
REQ-001 DEPTH, 4, operand FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  queue can accept an operation.
REQ-006 in_a, in_b  input  8 each  operands.
REQ-007 in_mode  input  1  0 = A+B, 1 = A-B.
REQ-008 add_a, add_b  output  8 each  operands driven to the external 8-bit controlled adder/subtractor.
REQ-009 add_mode  output  1  mode driven to the external adder/subtractor.
REQ-010 add_result  input  8  combinational result returned by the external adder/subtractor.
REQ-011 out_valid  output  1  out_* holds a completed result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_result  output  8  registered result.
REQ-014 out_carry  output  1  unsigned carry-out (mode 0) or no-borrow (mode 1).
REQ-015 out_ovf  output  1  signed two's-complement overflow.
REQ-016 out_zero  output  1  out_result == 0.
REQ-017 op_count  output  16  number of results consumed downstream.

Function
REQ-018 The block SHALL store {in_a, in_b, in_mode} in a DEPTH-entry FIFO on every edge with in_valid && in_ready.
REQ-019 in_ready SHALL equal (fifo count < DEPTH); there is no bypass when full, even on a same-cycle pop.
REQ-020 add_a/add_b/add_mode SHALL combinationally mirror the FIFO head entry; they SHALL be 0 when the FIFO is empty.
REQ-021 Load condition: FIFO non-empty && (!out_valid || out_ready); on a load edge the output register SHALL capture add_result, flags, and set out_valid=1, and the FIFO SHALL pop.
REQ-022 On an edge where out_valid && out_ready and no load occurs, out_valid SHALL clear; out_result and flags hold their last values.
REQ-023 Flags use a7=head A[7], b7=head B[7], r7=add_result[7]; mode 0: carry=(a7&b7)|((a7|b7)&~r7), ovf=(a7==b7)&&(r7!=a7); mode 1: carry=(a7&~b7)|((a7|~b7)&~r7), ovf=(a7!=b7)&&(r7!=a7).
REQ-024 out_* SHALL be stable while out_valid && !out_ready.
REQ-025 Latency: an operation accepted into an empty block at edge k SHALL appear with out_valid=1 after edge k+1; sustained throughput is one result per cycle when out_ready is held 1.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-027 op_count SHALL increment on each out_valid && out_ready edge, wrapping 0xFFFF -> 0x0000.
REQ-028 Results SHALL leave in acceptance order; no operation is dropped or duplicated.
REQ-029 Arithmetic is modulo 2^8; the block itself performs no addition beyond the flag equations.

Reset
REQ-030 rst_n low SHALL immediately clear FIFO count and pointers, out_valid, out_result, out_carry, out_ovf, op_count to 0, and out_zero to 0.
REQ-031 During reset in_ready SHALL be 0; it rises to 1 on the first edge after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all queued and pending results; no partial result appears after release.

Verification
REQ-033 Single add: push A=0x7F, B=0x01, mode 0, out_ready=1 -> one cycle later out_result=0x80, carry=0, ovf=1, zero=0, op_count=1.
REQ-034 Single subtract: push A=0x05, B=0x05, mode 1 -> out_result=0x00, carry=1, ovf=0, zero=1.
REQ-035 Backpressure/full: out_ready=0, push DEPTH+1 ops -> in_ready=0 after DEPTH+1 accepted (DEPTH queued + 1 in output); raise out_ready -> all results drain in order, one per cycle.
REQ-036 Full with simultaneous events: queue full, out_ready=1 and in_valid=1 same cycle -> no push that cycle, one pop, in_ready=1 next cycle.
REQ-037 Reset mid-stream: assert rst_n=0 with 3 ops queued -> out_valid=0, op_count=0 immediately; after release no stale result emerges.
REQ-038 Counter wrap: preload via 65535 consumed ops then one more -> op_count=0x0000.

Source files
------------

// File: rtl/addsub_issue_queue.sv
// Operand FIFO feeding an external 8-bit adder/subtractor, with a registered
// result stage that derives carry/overflow/zero flags and counts consumed results.
module addsub_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_mode,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_mode,
  input  logic [7:0]  add_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_result,
  output logic        out_carry,
  output logic        out_ovf,
  output logic        out_zero,
  output logic [15:0] op_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid/data never wait on ready and are held stable until the transfer.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_a_q [DEPTH];
  logic [7:0]    mem_b_q [DEPTH];
  logic          mem_m_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          init_q;

  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_result_q, out_result_d;
  logic          out_carry_q, out_carry_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_zero_q, out_zero_d;
  logic [15:0]   op_count_q, op_count_d;

  logic          empty;
  logic          push;
  logic          load;
  logic          consume;
  logic          a7, b7, r7;
  logic          carry_c, ovf_c;

  assign empty    = (count_q == '0);
  // init_q holds in_ready low until the first edge after reset release
  assign in_ready = init_q && (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;
  assign load     = !empty && (!out_valid_q || out_ready);

  assign add_a    = empty ? 8'h00 : mem_a_q[rd_ptr_q];
  assign add_b    = empty ? 8'h00 : mem_b_q[rd_ptr_q];
  assign add_mode = empty ? 1'b0  : mem_m_q[rd_ptr_q];

  assign a7 = add_a[7];
  assign b7 = add_b[7];
  assign r7 = add_result[7];

  always_comb begin
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    if (!add_mode) begin
      carry_c = (a7 & b7) | ((a7 | b7) & ~r7);
      ovf_c   = (a7 == b7) && (r7 != a7);
    end else begin
      // subtract: carry is "no borrow"
      carry_c = (a7 & ~b7) | ((a7 | ~b7) & ~r7);
      ovf_c   = (a7 != b7) && (r7 != a7);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_ovf_d    = out_ovf_q;
    out_zero_d   = out_zero_q;
    op_count_d   = op_count_q;
    if (consume) op_count_d = op_count_q + 16'd1;
    if (load) begin
      out_valid_d  = 1'b1;
      out_result_d = add_result;
      out_carry_d  = carry_c;
      out_ovf_d    = ovf_c;
      out_zero_d   = (add_result == 8'h00);
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
      mem_m_q[wr_ptr_q] <= in_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      init_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 8'h00;
      out_carry_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_zero_q   <= 1'b0;
      op_count_q   <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      init_q       <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_ovf_q    <= out_ovf_d;
      out_zero_q   <= out_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_ovf    = out_ovf_q;
  assign out_zero   = out_zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_issue_queue.sv
// Directed bench for addsub_issue_queue; the external adder/subtractor is
// modelled by a continuous assignment driven from add_a/add_b/add_mode.
module tb_addsub_issue_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_mode;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_mode;
  logic [7:0]  add_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_result;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic [15:0] op_count;

  int tests_run;
  int tests_failed;

  addsub_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_mode   (add_mode),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .op_count   (op_count)
  );

  assign add_result = add_mode ? (add_a - add_b) : (add_a + add_b);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one op and hold it until accepted (bounded)
  task automatic do_push(input logic [7:0] a, input logic [7:0] b, input logic m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    #12;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (op_count !== 16'h0000) begin tests_failed++; $display("FAIL rst_op_count: got %h want 0000", op_count); end
    tests_run++;
    if ({out_result, out_carry, out_ovf, out_zero} !== 11'h000) begin
      tests_failed++;
      $display("FAIL rst_out_regs: got %h/%b/%b/%b want 00/0/0/0", out_result, out_carry, out_ovf, out_zero);
    end
    tests_run++;
    if ({add_a, add_b, add_mode} !== 17'h00000) begin
      tests_failed++; $display("FAIL rst_head_zero: got %h/%h/%b want 00/00/0", add_a, add_b, add_mode);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_release_ready_early: got %b want 0", in_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    do_push(8'h7F, 8'h01, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || add_a !== 8'h7F || add_b !== 8'h01 || add_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_head: got v=%b a=%h b=%h m=%b want v=0 a=7f b=01 m=0", out_valid, add_a, add_b, add_mode);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, out_result, out_carry, out_ovf, out_zero} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_result: got v=%b r=%h c=%b o=%b z=%b want v=1 r=80 c=0 o=1 z=0",
               out_valid, out_result, out_carry, out_ovf, out_zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (op_count !== 16'd1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL add_consume: got cnt=%0d v=%b want cnt=1 v=0", op_count, out_valid);
    end
  endtask

  task automatic test_single_sub();
    out_ready = 1'b1;
    do_push(8'h05, 8'h05, 1'b1);
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, out_result, out_carry, out_ovf, out_zero} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub_result: got v=%b r=%h c=%b o=%b z=%b want v=1 r=00 c=1 o=0 z=1",
               out_valid, out_result, out_carry, out_ovf, out_zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (op_count !== 16'd2) begin tests_failed++; $display("FAIL sub_count: got %0d want 2", op_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vm [5];
    logic [7:0] er [5];
    logic       ec [5];
    logic       eo [5];
    va = '{8'h10, 8'hFF, 8'h80, 8'h03, 8'h64};
    vb = '{8'h20, 8'h01, 8'h01, 8'h05, 8'h64};
    vm = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    er = '{8'h30, 8'h00, 8'h7F, 8'hFE, 8'hC8};
    ec = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    eo = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) do_push(va[i], vb[i], vm[i]);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_result !== er[0] || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_stable: got v=%b r=%h want v=1 r=%h", out_valid, out_result, er[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== er[i] || out_carry !== ec[i] || out_ovf !== eo[i]
          || out_zero !== (er[i] == 8'h00)) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: got v=%b r=%h c=%b o=%b z=%b want v=1 r=%h c=%b o=%b",
                 i, out_valid, out_result, out_carry, out_ovf, out_zero, er[i], ec[i], eo[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || op_count !== 16'd7) begin
      tests_failed++; $display("FAIL bp_done: got v=%b cnt=%0d want v=0 cnt=7", out_valid, op_count);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] exp_tail [4];
    exp_tail = '{8'd6, 8'd8, 8'd10, 8'd12};
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) do_push(8'(i), 8'(i), 1'b0);
    in_valid = 1'b1;
    in_a     = 8'd6;
    in_b     = 8'd6;
    in_mode  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL fs_full: got rdy=%b want 0", in_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_result !== 8'd4) begin
      tests_failed++; $display("FAIL fs_pop_no_push: got rdy=%b r=%0d want rdy=1 r=4", in_ready, out_result);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== exp_tail[i]) begin
        tests_failed++;
        $display("FAIL fs_order[%0d]: got v=%b r=%0d want v=1 r=%0d", i, out_valid, out_result, exp_tail[i]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (out_valid !== 1'b0 || op_count !== 16'd13) begin
      tests_failed++; $display("FAIL fs_done: got v=%b cnt=%0d want v=0 cnt=13", out_valid, op_count);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_push(8'h11, 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || op_count !== 16'h0000 || in_ready !== 1'b0 || add_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_rst: got v=%b cnt=%0d rdy=%b a=%h want v=0 cnt=0 rdy=0 a=00",
               out_valid, op_count, in_ready, add_a);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || op_count !== 16'h0000) begin
        tests_failed++;
        $display("FAIL mid_rst_stale[%0d]: got v=%b cnt=%0d want v=0 cnt=0", i, out_valid, op_count);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h01;
    in_b      = 8'h01;
    in_mode   = 1'b0;
    while (op_count !== 16'hFFFF && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (op_count !== 16'hFFFF || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_reach: got cnt=%h v=%b after %0d cycles want cnt=ffff v=1", op_count, out_valid, n);
    end
    @(posedge clk); #1;
    tests_run++;
    if (op_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: got %h want 0000", op_count); end
    repeat (DEPTH + 2) begin @(posedge clk); #1; end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_add();
    test_single_sub();
    test_backpressure();
    test_full_simultaneous();
    test_reset_midstream();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
